// File: rtl/onchip_ram_arbiter_if.sv
// -----------------------------------------------------------------------------
// onchip_ram_arbiter_if
//   Avalon-MM slave-side port bundle. The arbiter uses one instance per
//   requester (s0 = instruction master, s1 = data master).
//
//   address        word address (ADDR_W)
//   read / write   command strobes
//   byteenable     byte lanes for writes (BE_W)
//   writedata      write data (DATA_W)
//   waitrequest    command not accepted this cycle
//   readdata       read data (DATA_W)
//   readdatavalid  read data valid
//
//   The "master" modport is the requester's view; "slave" is the arbiter's view.
// -----------------------------------------------------------------------------
interface onchip_ram_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int BE_W   = DATA_W / 8
);
   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [BE_W-1:0]   byteenable;
   logic [DATA_W-1:0] writedata;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport master (
      output address, read, write, byteenable, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, byteenable, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/onchip_ram_arbiter.sv
// -----------------------------------------------------------------------------
// onchip_ram_arbiter
//   Two-port Avalon-MM arbiter in front of one single-port on-chip RAM
//   (1-cycle read latency). At most one RAM command is issued per cycle; read
//   data is returned to the port that issued the read with readdatavalid.
//
//   clk            system clock
//   reset          synchronous, active-high
//   s0, s1         requester ports (onchip_ram_arbiter_if.slave)
//   freeze         blocks new grants while high
//   ram_address    RAM word address
//   ram_byteenable RAM byte enables
//   ram_chipselect RAM chipselect (high on every granted command)
//   ram_write      RAM write strobe
//   ram_writedata  RAM write data
//   ram_readdata   RAM read data, valid one cycle after the read is issued
//
//   FIXED_PRIO = 0 : round-robin on ties; 1 : port 0 always wins ties.
// -----------------------------------------------------------------------------
module onchip_ram_arbiter #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 32,
   parameter int BE_W       = DATA_W / 8,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   onchip_ram_arbiter_if.slave  s0,
   onchip_ram_arbiter_if.slave  s1,
   input  logic                 freeze,
   output logic [ADDR_W-1:0]    ram_address,
   output logic [BE_W-1:0]      ram_byteenable,
   output logic                 ram_chipselect,
   output logic                 ram_write,
   output logic [DATA_W-1:0]    ram_writedata,
   input  logic [DATA_W-1:0]    ram_readdata
);

   logic req0, req1;
   logic gnt0, gnt1;
   logic last_grant;   // 0 = port 0 granted last, 1 = port 1
   logic rd_accept;
   logic rd_pend;
   logic rd_owner;     // port that owns the read in flight

   assign req0 = s0.read | s0.write;
   assign req1 = s1.read | s1.write;

   // Grant is decided in the same cycle as the request.
   // NOTE: every output of an always_comb gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset && !freeze) begin
         if (req0 && req1) begin
            // On a tie, the port that did not win last time gets the RAM.
            if (FIXED_PRIO || last_grant) gnt0 = 1'b1;
            else                          gnt1 = 1'b1;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   assign s0.waitrequest = ~gnt0;
   assign s1.waitrequest = ~gnt1;

   // RAM command. With no grant the data path idles on port 0 and only the
   // chipselect/write strobes are forced low.
   assign ram_chipselect = gnt0 | gnt1;
   assign ram_write      = (gnt0 & s0.write) | (gnt1 & s1.write);
   assign ram_address    = gnt1 ? s1.address    : s0.address;
   assign ram_byteenable = gnt1 ? s1.byteenable : s0.byteenable;
   assign ram_writedata  = gnt1 ? s1.writedata  : s0.writedata;

   // read+write together counts as a write, so it never creates a read return.
   assign rd_accept = (gnt0 & s0.read & ~s0.write) | (gnt1 & s1.read & ~s1.write);

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pend    <= 1'b0;
         rd_owner   <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         rd_pend <= rd_accept;
         if (rd_accept)    rd_owner   <= gnt1;
         if (gnt0 || gnt1) last_grant <= gnt1;
      end
   end

   // A read accepted just before reset must not surface while reset is high.
   assign s0.readdatavalid = rd_pend & ~rd_owner & ~reset;
   assign s1.readdatavalid = rd_pend &  rd_owner & ~reset;
   assign s0.readdata      = ram_readdata;
   assign s1.readdata      = ram_readdata;

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_onchip_ram_arbiter
//   Directed bench. dut_rr (FIXED_PRIO=0) sits in front of a behavioural
//   4096x32 byte-enabled RAM with 1-cycle read latency; dut_fp (FIXED_PRIO=1)
//   is used for the fixed-priority grant sequence only.
//   Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_onchip_ram_arbiter;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   logic clk = 1'b0;
   logic reset;
   logic freeze;

   always #5 clk = ~clk;

   onchip_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) p0 ();
   onchip_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) p1 ();
   onchip_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) q0 ();
   onchip_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) q1 ();

   logic [ADDR_W-1:0] a_addr, b_addr;
   logic [BE_W-1:0]   a_be, b_be;
   logic              a_cs, b_cs, a_we, b_we;
   logic [DATA_W-1:0] a_wd, b_wd, a_rd;
   logic [DATA_W-1:0] b_rd;

   onchip_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .FIXED_PRIO(1'b0)) dut_rr (
      .clk(clk), .reset(reset), .s0(p0), .s1(p1), .freeze(freeze),
      .ram_address(a_addr), .ram_byteenable(a_be), .ram_chipselect(a_cs),
      .ram_write(a_we), .ram_writedata(a_wd), .ram_readdata(a_rd)
   );

   onchip_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .FIXED_PRIO(1'b1)) dut_fp (
      .clk(clk), .reset(reset), .s0(q0), .s1(q1), .freeze(freeze),
      .ram_address(b_addr), .ram_byteenable(b_be), .ram_chipselect(b_cs),
      .ram_write(b_we), .ram_writedata(b_wd), .ram_readdata(b_rd)
   );

   assign b_rd = '0;

   // Behavioural RAM behind dut_rr, with a preload port used during reset.
   logic [DATA_W-1:0] mem [0:4095];
   logic              pl_en;
   logic [ADDR_W-1:0] pl_addr;
   logic [DATA_W-1:0] pl_data;

   always @(posedge clk) begin
      if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end else if (a_cs) begin
         if (a_we) begin
            for (int b = 0; b < BE_W; b++)
               if (a_be[b]) mem[a_addr][8*b +: 8] <= a_wd[8*b +: 8];
         end else begin
            a_rd <= mem[a_addr];
         end
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle_all();
      p0.read = 0; p0.write = 0; p0.address = '0; p0.byteenable = '1; p0.writedata = '0;
      p1.read = 0; p1.write = 0; p1.address = '0; p1.byteenable = '1; p1.writedata = '0;
      q0.read = 0; q0.write = 0; q0.address = '0; q0.byteenable = '1; q0.writedata = '0;
      q1.read = 0; q1.write = 0; q1.address = '0; q1.byteenable = '1; q1.writedata = '0;
   endtask

   int cnt0, cnt1;

   initial begin
      reset = 1; freeze = 0; idle_all();
      pl_en = 1; pl_addr = 12'h010; pl_data = 32'hDEADBEEF;
      step();
      pl_addr = 12'h000; pl_data = 32'hA0A0A0A0;
      step();
      pl_addr = 12'h800; pl_data = 32'hB0B0B0B0;
      p0.read = 1; p0.address = 12'h010; q0.read = 1; q1.write = 1;

      // ---- reset state, with requests present ----
      sample();
      check("rst_wr0", p0.waitrequest, 1);
      check("rst_wr1", p1.waitrequest, 1);
      check("rst_cs", a_cs, 0);
      check("rst_we", a_we, 0);
      check("rst_rdv0", p0.readdatavalid, 0);
      check("rst_rdv1", p1.readdatavalid, 0);
      check("rst_fp_wr0", q0.waitrequest, 1);
      check("rst_fp_cs", b_cs, 0);
      step();
      pl_en = 0; reset = 0; q0.read = 0; q1.write = 0;

      // ---- single read from port 0 ----
      sample();
      check("rd_wr0", p0.waitrequest, 0);
      check("rd_cs", a_cs, 1);
      check("rd_we", a_we, 0);
      check("rd_addr", a_addr, 32'h010);
      step();
      p0.read = 0;
      sample();
      check("rd_rdv0", p0.readdatavalid, 1);
      check("rd_data0", p0.readdata, 32'hDEADBEEF);
      check("rd_rdv1", p1.readdatavalid, 0);
      check("idle_wr1", p1.waitrequest, 1);
      check("idle_cs", a_cs, 0);
      step();

      // ---- round-robin contention after reset ----
      reset = 1;
      step();
      reset = 0;
      p0.read = 1; p0.address = 12'h000;
      p1.read = 1; p1.address = 12'h800;
      cnt0 = 0; cnt1 = 0;
      for (int c = 0; c < 8; c++) begin
         sample();
         if (!p0.waitrequest) cnt0++;
         if (!p1.waitrequest) cnt1++;
         check($sformatf("rr_wr0_c%0d", c), p0.waitrequest, (c % 2 == 1));
         check($sformatf("rr_wr1_c%0d", c), p1.waitrequest, (c % 2 == 0));
         check($sformatf("rr_rdv0_c%0d", c), p0.readdatavalid, (c % 2 == 1));
         check($sformatf("rr_rdv1_c%0d", c), p1.readdatavalid, (c % 2 == 0) && (c > 0));
         if (c % 2 == 1) check($sformatf("rr_data0_c%0d", c), p0.readdata, 32'hA0A0A0A0);
         if (c % 2 == 0 && c > 0) check($sformatf("rr_data1_c%0d", c), p1.readdata, 32'hB0B0B0B0);
         step();
      end
      check("rr_cnt0", cnt0, 4);
      check("rr_cnt1", cnt1, 4);
      p0.read = 0; p1.read = 0;
      sample();
      check("rr_tail_rdv1", p1.readdatavalid, 1);
      check("rr_tail_data1", p1.readdata, 32'hB0B0B0B0);
      check("rr_tail_rdv0", p0.readdatavalid, 0);
      step();

      // ---- byte-enabled writes from port 1, read back on port 0 ----
      p1.write = 1; p1.address = 12'h005; p1.writedata = 32'h11223344; p1.byteenable = 4'b1111;
      sample();
      check("bw1_wr1", p1.waitrequest, 0);
      check("bw1_we", a_we, 1);
      step();
      p1.writedata = 32'hAA000000; p1.byteenable = 4'b1000;
      sample();
      check("bw2_wr1", p1.waitrequest, 0);
      check("bw2_be", a_be, 32'h8);
      step();
      p1.write = 0; p1.byteenable = 4'b1111;
      p0.read = 1; p0.address = 12'h005;
      sample();
      check("bw_rd_wr0", p0.waitrequest, 0);
      step();
      p0.read = 0;
      sample();
      check("bw_rdv0", p0.readdatavalid, 1);
      check("bw_data0", p0.readdata, 32'hAA223344);
      step();

      // ---- read and write together on port 1 is a write ----
      p1.read = 1; p1.write = 1; p1.address = 12'h006; p1.writedata = 32'h00000055;
      sample();
      check("rw_wr1", p1.waitrequest, 0);
      check("rw_we", a_we, 1);
      step();
      p1.read = 0; p1.write = 0;
      sample();
      check("rw_rdv1", p1.readdatavalid, 0);
      step();

      // ---- freeze after an accepted read ----
      p0.read = 1; p0.address = 12'h010;
      sample();
      check("fz_acc_wr0", p0.waitrequest, 0);
      step();
      freeze = 1;
      p0.address = 12'h000;
      p1.read = 1; p1.address = 12'h800;
      sample();
      check("fz_rdv0", p0.readdatavalid, 1);
      check("fz_data0", p0.readdata, 32'hDEADBEEF);
      check("fz_wr0_a", p0.waitrequest, 1);
      check("fz_wr1_a", p1.waitrequest, 1);
      check("fz_cs_a", a_cs, 0);
      step();
      sample();
      check("fz_wr0_b", p0.waitrequest, 1);
      check("fz_wr1_b", p1.waitrequest, 1);
      check("fz_rdv0_b", p0.readdatavalid, 0);
      step();
      freeze = 0;
      // Port 0 won last, so port 1 takes the first tie after freeze.
      sample();
      check("fz_rel_wr1", p1.waitrequest, 0);
      check("fz_rel_wr0", p0.waitrequest, 1);
      step();
      p1.read = 0;
      sample();
      check("fz_rel2_wr0", p0.waitrequest, 0);
      check("fz_rel2_rdv1", p1.readdatavalid, 1);
      check("fz_rel2_data1", p1.readdata, 32'hB0B0B0B0);
      step();
      p0.read = 0;
      sample();
      check("fz_rel3_rdv0", p0.readdatavalid, 1);
      check("fz_rel3_data0", p0.readdata, 32'hA0A0A0A0);
      step();

      // ---- reset in the cycle after a read accept ----
      p0.read = 1; p0.address = 12'h010;
      sample();
      check("mr_acc_wr0", p0.waitrequest, 0);
      step();
      p0.read = 0; reset = 1;
      sample();
      check("mr_rst_rdv0", p0.readdatavalid, 0);
      check("mr_rst_rdv1", p1.readdatavalid, 0);
      step();
      reset = 0;
      p0.read = 1; p0.address = 12'h000;
      p1.read = 1; p1.address = 12'h800;
      sample();
      check("mr_post_rdv0", p0.readdatavalid, 0);
      check("mr_post_rdv1", p1.readdatavalid, 0);
      check("mr_tie_wr0", p0.waitrequest, 0);
      check("mr_tie_wr1", p1.waitrequest, 1);
      step();
      p0.read = 0; p1.read = 0;
      sample();
      check("mr_tie_rdv0", p0.readdatavalid, 1);
      step();

      // ---- fixed priority: port 0 always wins ties ----
      q0.read = 1; q0.address = 12'h001;
      q1.read = 1; q1.address = 12'h002;
      for (int c = 0; c < 5; c++) begin
         sample();
         check($sformatf("fp_wr1_c%0d", c), q1.waitrequest, 1);
         check($sformatf("fp_wr0_c%0d", c), q0.waitrequest, 0);
         step();
      end
      q0.read = 0;
      sample();
      check("fp_rel_wr1", q1.waitrequest, 0);
      check("fp_rel_addr", b_addr, 32'h002);
      step();
      q1.read = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/onchip_ram_arbiter.md
Name: onchip_ram_arbiter

Overview:
- Two-port Avalon-MM arbiter in front of one single-port on-chip RAM: 4096 x 32 words, byte enables, 1-cycle read latency.
- Typical requesters: Nios II instruction master (port 0) and data master (port 1). Both share one RAM instance without a fabric arbiter.
- Issues at most one RAM command per cycle and returns read data to the owning port with readdatavalid.

Parameters:
- ADDR_W, 12, RAM word-address width.
- DATA_W, 32, data width.
- BE_W, 4, byteenable width (DATA_W/8).
- FIXED_PRIO, 0: 0 = round-robin; 1 = port 0 always wins.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- s0_address  in  ADDR_W  port 0 word address
- s0_read  in  1  port 0 read request
- s0_write  in  1  port 0 write request
- s0_byteenable  in  BE_W  port 0 byte enables
- s0_writedata  in  DATA_W  port 0 write data
- s0_waitrequest  out  1  port 0 command not accepted this cycle
- s0_readdata  out  DATA_W  port 0 read data
- s0_readdatavalid  out  1  port 0 read data valid
- s1_* (address, read, write, byteenable, writedata, waitrequest, readdata, readdatavalid)  same as s0_*  port 1
- freeze  in  1  blocks new grants while high
- ram_address  out  ADDR_W  to RAM address
- ram_byteenable  out  BE_W  to RAM byteenable
- ram_chipselect  out  1  to RAM chipselect
- ram_write  out  1  to RAM write
- ram_writedata  out  DATA_W  to RAM writedata
- ram_readdata  in  DATA_W  from RAM, valid 1 cycle after read issue

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. The RAM clock enable is tied high outside this block.
- Requests: req_n = sN_read | sN_write. A port asserting both read and write is treated as a write.
- Grant (combinational, same cycle):
  - No grant if reset or freeze is high, or no request.
  - If only one port requests, it is granted.
  - If both request: FIXED_PRIO=1 grants port 0. FIXED_PRIO=0 grants the port not in last_grant.
- Accept:
  - Granted port sees waitrequest=0 in that cycle; the command completes in that cycle.
  - A requesting, ungranted port sees waitrequest=1 and must hold its command stable.
  - A non-requesting port sees waitrequest=1 when not granted.
  - waitrequest is 1 on both ports while reset or freeze is high.
- RAM drive:
  - On grant, ram_* carry the granted port's command: chipselect=1, write=sN_write, plus address, byteenable and writedata.
  - With no grant: chipselect=0, write=0; address, byteenable and writedata are driven from port 0.
- last_grant register: updated to the granted port on every grant; reset value is 1, so port 0 wins the first tie.
- Read return pipeline:
  - Registers rd_pend (reset 0) and rd_owner.
  - On an accepted read, rd_pend<=1 and rd_owner<=port; otherwise rd_pend<=0.
  - sN_readdatavalid = rd_pend & (rd_owner==N); sN_readdata = ram_readdata on both ports.
  - Read latency is exactly 1 cycle after accept.
  - Back-to-back reads issue every cycle at full throughput, including alternating ports.
- Writes: no response; data is in RAM from the cycle after accept.
- Freeze: blocks new grants only. A read already accepted still returns its readdatavalid in the next cycle.
- Reset:
  - Any pending read is dropped: readdatavalid=0 in every cycle in which reset is sampled high, and in the first cycle after.
  - last_grant returns to 1.
- Reset values: s0/s1_readdatavalid=0, s0/s1_waitrequest=1, ram_chipselect=0, ram_write=0.
- Simultaneous events:
  - Same-cycle read on one port and write on the other to the same address: the grant order decides, no special hazard handling.
  - Read-during-write behaviour is the RAM's "don't care". Only one command ever reaches the RAM per cycle, so it cannot occur.

Test Plan:
- Single read: s0 reads addr 0x010, RAM holds 0xDEADBEEF -> s0_waitrequest=0 at cycle T; s0_readdatavalid=1 with 0xDEADBEEF at T+1; s1_readdatavalid stays 0.
- Round-robin contention: both ports read continuously from 0x000 / 0x800 (FIXED_PRIO=0) after reset.
  - Grants go 0,1,0,1.
  - Each port gets exactly 4 of 8 cycles.
  - readdatavalid alternates 0,1 per port, with a 1-cycle lag.
- Fixed priority (FIXED_PRIO=1): both request for 5 cycles -> port 1 waitrequest=1 for all 5; port 1 is granted in the first cycle port 0 deasserts.
- Byte write then read: s1 writes 0x11223344 with byteenable=4'b1111 to 0x005, then 0xAA000000 with byteenable=4'b1000; s0 reads 0x005 -> 0xAA223344.
- Freeze: freeze rises the cycle after s0's read is accepted -> readdatavalid still fires; new requests see waitrequest=1 until freeze falls, then are granted.
- Reset mid-read: reset asserted in the cycle after a read accept.
  - No readdatavalid appears on either port.
  - After reset, a tie is granted to port 0.
